// File: rtl/plugin_arbiter_if.sv
// Bundle between the plugin arbiter and its requesters plus the shared accelerator.
// slave = arbiter side, master = requesters/plugin side.
interface plugin_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_operand_a;
  logic [NUM_REQ*32-1:0] req_operand_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_result;
  logic                  rsp_error;
  logic                  plugin_start;
  logic [31:0]           plugin_operand_a;
  logic [31:0]           plugin_operand_b;
  logic [31:0]           plugin_result;
  logic                  plugin_busy;
  logic                  plugin_done;
  logic                  active;
  logic [1:0]            grant_id;

  modport slave (
    input  req_valid, req_operand_a, req_operand_b, rsp_ready,
           plugin_result, plugin_busy, plugin_done,
    output req_ready, rsp_valid, rsp_result, rsp_error,
           plugin_start, plugin_operand_a, plugin_operand_b, active, grant_id
  );

  modport master (
    output req_valid, req_operand_a, req_operand_b, rsp_ready,
           plugin_result, plugin_busy, plugin_done,
    input  req_ready, rsp_valid, rsp_result, rsp_error,
           plugin_start, plugin_operand_a, plugin_operand_b, active, grant_id
  );
endinterface

// File: rtl/plugin_arbiter.sv
// Round-robin sequencer sharing one start/busy/done plugin; >=3 cycles per op (2+k after grant).
// Accepts one request only in IDLE; response held until the owner's rsp_ready.
module plugin_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             reset_n,
  plugin_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         last_grant;
  logic [1:0]         owner;
  logic [1:0]         winner;
  logic               found;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_rdy;
  logic [TW-1:0]      timer;
  logic               timer_hit;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic [31:0]        result;
  logic               error;
  logic               busy_unused;

  assign busy_unused = bus.plugin_busy;

  // Two passes give the wrap-around search starting just above last_grant.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i > int'(last_grant) && bus.req_valid[i]) begin
        found  = 1'b1;
        winner = i[1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i <= int'(last_grant) && bus.req_valid[i]) begin
        found  = 1'b1;
        winner = i[1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == i[1:0]) begin
        sel_a = bus.req_operand_a[i*32 +: 32];
        sel_b = bus.req_operand_b[i*32 +: 32];
      end
    end
  end

  assign win_oh    = NUM_REQ'(1) << winner;
  assign owner_oh  = NUM_REQ'(1) << owner;
  assign owner_rdy = |(bus.rsp_ready & owner_oh);
  assign timer_hit = (timer == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = bus.plugin_done ? RESP : WAIT;
      WAIT:    if (bus.plugin_done || timer_hit) state_nxt = RESP;
      RESP:    if (owner_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 2'(NUM_REQ - 1);
      owner      <= '0;
      timer      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            owner <= winner;
          end
        end
        ISSUE: begin
          if (bus.plugin_done) begin
            result <= bus.plugin_result;
            error  <= 1'b0;
          end else begin
            timer <= TW'(1);
          end
        end
        WAIT: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (bus.plugin_done) begin
            result <= bus.plugin_result;
            error  <= 1'b0;
          end else if (timer_hit) begin
            result <= '0;
            error  <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          if (owner_rdy) last_grant <= owner;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready        = (state == IDLE && found) ? win_oh : '0;
  assign bus.rsp_valid        = (state == RESP) ? owner_oh : '0;
  assign bus.rsp_result       = result;
  assign bus.rsp_error        = (state == RESP) && error;
  assign bus.plugin_start     = (state == ISSUE);
  assign bus.plugin_operand_a = op_a;
  assign bus.plugin_operand_b = op_b;
  assign bus.active           = (state != IDLE);
  assign bus.grant_id         = owner;
endmodule

// File: doc/plugin_arbiter.md
# plugin_arbiter

Sequencer and round-robin arbiter that shares one RS5 plugin accelerator (start/busy/done interface, e.g. the A+B+5 adder plugin) between up to four requesters. Possible requesters are the core's execute stage, a second hart, or a DMA engine. It accepts one request at a time over a valid/ready handshake and latches its operands. It then issues a one-cycle start pulse to the plugin, waits for done (with a timeout), and returns the result to the owning requester over a per-requester valid/ready response channel.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, legal range 1..4.
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles after start before the request is aborted. Legal range 1..65535.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept; one-hot or zero.
- req_operand_a  in  NUM_REQ*32  operand A; requester i uses bits [32i+31:32i].
- req_operand_b  in  NUM_REQ*32  operand B, same packing as operand A.
- rsp_valid  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  32  result for the requester whose rsp_valid is high.
- rsp_error  out  1  high with rsp_valid when the request timed out.
- plugin_start  out  1  start pulse to the plugin.
- plugin_operand_a  out  32  latched operand A.
- plugin_operand_b  out  32  latched operand B.
- plugin_result  in  32  plugin result, sampled when plugin_done is high.
- plugin_busy  in  1  plugin busy; status only, not used for sequencing.
- plugin_done  in  1  plugin completion; may be high in the same cycle as plugin_start.
- active  out  1  high in every state except IDLE.
- grant_id  out  2  index of the current owner; holds the last owner while IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - plugin_start=0.
  - If any req_valid is high, the winner is the first requester with req_valid set, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - req_ready[winner]=1 combinationally in this cycle.
  - At the clock edge: latch that requester's operands, set owner=winner, go to ISSUE.
- ISSUE
  - plugin_start=1 for exactly this cycle; plugin operands come from the latches.
  - If plugin_done=1 this cycle: capture plugin_result, clear the error flag, go to RESP.
  - Otherwise: set timer=1, go to WAIT.
- WAIT
  - plugin_start=0.
  - If plugin_done=1: capture plugin_result, error=0, go to RESP.
  - Else if timer==TIMEOUT_CYCLES: result=0, error=1, go to RESP.
  - Else increment timer.
  - Timer width is clog2(TIMEOUT_CYCLES+1); the timer never wraps.
- RESP
  - rsp_valid[owner]=1; rsp_result and rsp_error are held stable.
  - When rsp_ready[owner]=1: set last_grant=owner, go to IDLE.
  - rsp_ready on non-owner lines is ignored.
- plugin_done in IDLE or RESP is ignored.
- req_ready is 0 in ISSUE, WAIT and RESP. New requests are accepted only in IDLE; a request is never accepted in the same cycle as a response handshake.
- Operand latches, plugin_operand_a/b and grant_id change only on a request handshake.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 wins first.
  - timer=0; result and operand latches=0; error=0; owner=0.
  - All outputs 0: req_ready, rsp_valid, rsp_result, rsp_error, plugin_start, plugin_operand_a/b, active, grant_id.
- Reset in ISSUE, WAIT or RESP discards the transaction without a response. The late plugin_done after reset is ignored because the FSM is in IDLE.
- Single-cycle plugin: request handshake in cycle N, plugin_start in N+1, rsp_valid from N+2. Minimum 3 cycles per operation with rsp_ready tied high.
- Multi-cycle plugin with done k cycles after start: rsp_valid from N+2+k.
- Timeout: with no done, rsp_valid with rsp_error=1 rises at N+2+TIMEOUT_CYCLES.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 other transactions.

## Test plan
- Instantiated A+B+5 adder plugin, req0 sends a=10, b=20 → handshake in cycle 0, plugin_start in cycle 1, rsp_valid[0] in cycle 2 with rsp_result=35 and rsp_error=0. Also a=0xFFFFFFFF, b=0 → result 4 (32-bit wrap).
- req0 and req1 held valid continuously with distinct operands → grants alternate 0,1,0,1; every response goes to the correct rsp_valid bit with the matching result; grant_id tracks the owner.
- Stub plugin asserting done 4 cycles after start with result 0xDEADBEEF → rsp_valid 6 cycles after handshake, result 0xDEADBEEF; plugin_start high for exactly one cycle.
- Stub plugin never asserting done, TIMEOUT_CYCLES=8 → rsp_valid at handshake+10 with rsp_error=1 and rsp_result=0; the next request completes normally.
- rsp_ready held low for 5 cycles in RESP → rsp_valid and rsp_result stay stable, req_ready stays 0 for a waiting req1; req1 is granted the cycle after rsp_ready rises.
- reset_n pulsed low in WAIT → all outputs 0 immediately; a later plugin_done pulse produces no response; a subsequent req1-only request is granted normally.
